// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED driver for the life grid. A shadow buffer captures new grids;
// they reach the display buffer only at a frame boundary (or while idle).
module led_matrix_scan #(
  parameter int ROW_DWELL    = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] grid_in,
  input  logic        load,
  input  logic        enable,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        load_ack,
  output logic        frame_done
);

  localparam int MAXC = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(ROW_DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  // Scan handshake: a load is accepted every cycle it is high (no back-pressure);
  // load_ack is a one-cycle pulse marking the cycle after shadow reaches the display.

  state_t        state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   disp_q, disp_d;
  logic [63:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [7:0]    row_sel_q, row_sel_d;
  logic [7:0]    col_data_q, col_data_d;
  logic          load_ack_q, load_ack_d;
  logic          frame_done_q, frame_done_d;
  logic          commit;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    load_ack_d   = 1'b0;
    frame_done_d = 1'b0;
    commit       = 1'b0;

    if (load) begin
      shadow_d  = grid_in;
      pending_d = 1'b1;
    end

    if (state_q != IDLE && !enable) begin
      state_d = IDLE;
      row_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          row_d  = '0;
          cnt_d  = '0;
          commit = pending_q;
          if (enable) state_d = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            row_d   = row_q + 3'd1;
            state_d = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
            if (row_q == 3'd7) begin
              frame_done_d = 1'b1;
              commit       = pending_q || load;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // A load landing on the commit edge bypasses the shadow so nothing is left pending.
    if (commit) begin
      disp_d     = load ? grid_in : shadow_q;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end

    // Outputs are registered from next-state so they line up with the state register.
    row_sel_d  = 8'h00;
    col_data_d = 8'h00;
    if (state_d == DRIVE) begin
      row_sel_d  = 8'h01 << row_d;
      col_data_d = disp_d[{row_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_sel    = row_sel_q;
  assign col_data   = col_data_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with ROW_DWELL=4, BLANK_CYCLES=2 (48-cycle frames).
module tb_led_matrix_scan;

  logic        clk;
  logic        rst;
  logic [63:0] grid_in;
  logic        load;
  logic        enable;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        load_ack;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int pos    = 0;

  localparam logic [63:0] GRID_X = 64'h8142_2418_1824_4281;
  localparam logic [63:0] GRID_B = 64'hFF00_0000_0000_00FF;
  localparam logic [63:0] GRID_C = 64'h0000_0000_0000_0001;
  localparam logic [63:0] GRID_D = 64'h0102_0408_1020_4080;
  localparam logic [63:0] GRID_E = 64'hFFFF_FFFF_FFFF_FFFF;

  led_matrix_scan #(.ROW_DWELL(4), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .grid_in    (grid_in),
    .load       (load),
    .enable     (enable),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s pos=%0d: observed %0h expected %0h", tag, pos, obs, exp);
  endtask

  // One scanning cycle: pos counts cycles since the edge that sampled enable.
  task automatic step(input logic [63:0] g, input logic exp_ack);
    int f, ph, r;
    logic [7:0] ers, ecol;
    logic efd;
    @(negedge clk);
    f    = pos % 48;
    ph   = f % 6;
    r    = f / 6;
    ers  = (ph < 2) ? 8'h00 : 8'(1 << r);
    ecol = (ph < 2) ? 8'h00 : g[r*8 +: 8];
    efd  = (pos > 0) && (f == 0);
    chk("row_sel", {56'd0, row_sel}, {56'd0, ers});
    chk("col_data", {56'd0, col_data}, {56'd0, ecol});
    chk("frame_done", {63'd0, frame_done}, {63'd0, efd});
    chk("load_ack", {63'd0, load_ack}, {63'd0, exp_ack});
    pos++;
  endtask

  task automatic idle_step(input logic exp_ack);
    @(negedge clk);
    chk("idle_row_sel", {56'd0, row_sel}, 64'd0);
    chk("idle_col_data", {56'd0, col_data}, 64'd0);
    chk("idle_frame_done", {63'd0, frame_done}, 64'd0);
    chk("idle_load_ack", {63'd0, load_ack}, {63'd0, exp_ack});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; grid_in = '0;
    idle_step(1'b0);
    idle_step(1'b0);
    rst = 1'b0;
    idle_step(1'b0);

    // Blank display scan over two frames.
    enable = 1'b1; pos = 0;
    for (int i = 0; i < 96; i++) step(64'd0, 1'b0);
    enable = 1'b0;
    idle_step(1'b0);
    idle_step(1'b0);

    // Load while dark: ack two cycles after load.
    load = 1'b1; grid_in = GRID_X;
    idle_step(1'b0);
    load = 1'b0;
    idle_step(1'b1);
    idle_step(1'b0);

    enable = 1'b1; pos = 0;
    for (int i = 0; i < 48; i++) step(GRID_X, 1'b0);

    // Loads B then C mid-frame: frame keeps showing X, single ack at wrap.
    for (int i = 0; i < 48; i++) begin
      step(GRID_X, 1'b0);
      if (i == 20) begin load = 1'b1; grid_in = GRID_B; end
      else if (i == 32) begin load = 1'b1; grid_in = GRID_C; end
      else load = 1'b0;
    end
    // Frame shows C; load D lands on the wrap edge itself.
    for (int i = 0; i < 48; i++) begin
      step(GRID_C, i == 0);
      if (i == 47) begin load = 1'b1; grid_in = GRID_D; end
      else load = 1'b0;
    end
    for (int i = 0; i < 48; i++) begin
      step(GRID_D, i == 0);
      load = 1'b0;
    end

    // Drop enable during row 4 drive.
    for (int i = 0; i < 28; i++) step(GRID_D, 1'b0);
    enable = 1'b0;
    idle_step(1'b0);
    idle_step(1'b0);
    idle_step(1'b0);
    enable = 1'b1; pos = 0;
    for (int i = 0; i < 10; i++) step(GRID_D, 1'b0);

    // Reset mid-drive with a pending load.
    load = 1'b1; grid_in = GRID_E;
    step(GRID_D, 1'b0);
    load = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_row_sel", {56'd0, row_sel}, 64'd0);
    chk("async_rst_col_data", {56'd0, col_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0; pos = 0;
    for (int i = 0; i < 54; i++) step(64'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Reader side of the 64-bit life grid: takes a grid word and displays it on an 8x8 LED matrix by row multiplexing.
- Holds a double-buffered frame (shadow plus display buffer). A new grid is committed only at a frame boundary, so one displayed frame never mixes two generations.
- Sits between the generation register and the board matrix pins, and acknowledges each load so the controller can pace evolution.

Parameters:
- ROW_DWELL, 1000: clock cycles each row is driven; must be >= 1.
- BLANK_CYCLES, 8: all-off cycles before each row (anti-ghosting); 0 means no blank phase.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- grid_in  input  64  grid word; bit r*8+c is row r (0..7), column c (0..7).
- load  input  1  when high, sample grid_in into shadow this cycle.
- enable  input  1  high = scan the matrix; low = matrix dark.
- row_sel  output  8  one-hot active-high row drive; 0 when dark.
- col_data  output  8  column drive; col_data[c] = disp[r*8+c] for the active row r; 0 when dark.
- load_ack  output  1  one-cycle pulse when the pending shadow is committed to the display buffer.
- frame_done  output  1  one-cycle pulse when row 7 finishes its dwell.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - disp = 0, shadow = 0, pending = 0.
  - row = 0, counter = 0, state = IDLE.
- All outputs are registered.
- Load path:
  - load sampled high -> shadow <= grid_in and pending <= 1 on the next edge.
  - Repeated loads while pending overwrite shadow (latest wins) and produce only one load_ack.
- States: IDLE, BLANK, DRIVE.
- IDLE (enable low):
  - row_sel = 0, col_data = 0, row = 0.
  - If pending: disp <= shadow, pending <= 0, load_ack pulses on the following cycle.
  - enable sampled high at edge T -> BLANK from T+1, or DRIVE if BLANK_CYCLES = 0.
- BLANK:
  - Outputs 0 for exactly BLANK_CYCLES cycles, then DRIVE.
- DRIVE:
  - row_sel = 1<<row and col_data = disp[row*8 +: 8] for exactly ROW_DWELL cycles.
  - At the end of the dwell: row <= row+1, then BLANK (or DRIVE).
- Frame wrap (row 7 end of dwell):
  - row wraps to 0 and frame_done pulses for one cycle.
  - If pending, commit disp <= shadow, clear pending, and pulse load_ack in the same cycle as frame_done.
  - The next frame shows the new grid.
- Simultaneous load and frame wrap: grid_in is committed directly to disp and shadow, and load_ack pulses; nothing is left pending.
- Timing: frame period = 8*(BLANK_CYCLES+ROW_DWELL) cycles; first lit cycle is T+1+BLANK_CYCLES after enable is sampled.
- enable deasserted mid-frame:
  - Next edge -> IDLE, outputs 0, row and counter cleared, no frame_done.
  - pending is preserved and commits in IDLE as above.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Shadow contents and a pending load are discarded.
- Widths: dwell/blank counter is $clog2(max(ROW_DWELL, BLANK_CYCLES)+1) bits; row counter is 3 bits, wrapping naturally.
- Column logic is not inverted here; board polarity is handled at the pins.

Test Plan:
- Bench parameters for all scenarios: ROW_DWELL=4, BLANK_CYCLES=2.
- Reset then enable=1 with disp 0:
  - row_sel pattern 0,0,01,01,01,01,0,0,02 ... continues through 80.
  - col_data always 0; frame_done pulses every 48 cycles.
- Load with enable low, grid_in=64'h8142_2418_1824_4281:
  - load_ack pulses 2 cycles later.
  - After enable: row 0 col_data=81, row 3 col_data=18, row 7 col_data=81.
- Scanning grid A, load grid B=64'hFF00_0000_0000_00FF mid-frame (row 3), then load C=64'h0000_0000_0000_0001 at row 5:
  - Rows 3..7 still show A.
  - Exactly one load_ack, coincident with frame_done.
  - Next frame row 0 col_data=01, all other rows 00.
- load asserted in the exact cycle of the row-7 wrap: grid_in is displayed from the next row 0, load_ack pulses with frame_done, and no second ack follows.
- enable dropped during row 4 DRIVE:
  - Next cycle row_sel=0 and col_data=0, with no frame_done.
  - Re-enable restarts at row 0 after 2 blank cycles.
- rst asserted mid-DRIVE with pending=1:
  - Outputs 0 asynchronously (before the next clk edge).
  - After release plus enable, display shows all zeros and no load_ack appears.
